t01_ai_move_scheduler: RTL

//  Sequences one AI move per new piece: launches t01_ai_placement_engine, walks its candidate

---
 rtl/t01_ai_move_scheduler.sv | 201 ++++++++++++++++++++
 1 files changed

// File: rtl/t01_ai_move_scheduler.sv
// t01_ai_move_scheduler: runs one AI move per new piece.
// Launches the placement engine, walks its candidate list through an external
// board evaluator one index at a time, keeps the best (signed, strict-greater)
// score, and reports the winning rotation/x to game control.
// Optional build macro: T01_AI_SCHED_TIMEOUT_EN adds a WAIT/EVAL watchdog that
// ends the move with no_move after TIMEOUT_CYC cycles.
module t01_ai_move_scheduler #(
  parameter int SCORE_W = 16
`ifdef T01_AI_SCHED_TIMEOUT_EN
  , parameter int TIMEOUT_CYC = 1023
`endif
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               piece_valid,
  input  logic [4:0]         piece_in,
  output logic [4:0]         pe_piece_type,
  output logic               pe_start,
  input  logic               pe_ready,
  input  logic [5:0]         pe_count,
  output logic [5:0]         cand_idx,
  input  logic [1:0]         cand_rot,
  input  logic [3:0]         cand_x,
  output logic               eval_req,
  input  logic               eval_ack,
  input  logic [SCORE_W-1:0] eval_score,
  input  logic               abort,
  output logic               busy,
  output logic               move_valid,
  output logic               no_move,
  output logic [1:0]         best_rot,
  output logic [3:0]         best_x,
  output logic [SCORE_W-1:0] best_score
);

  typedef enum logic [2:0] {
    IDLE, LAUNCH, WAIT, ISSUE, EVAL, RELEASE, DONE
  } state_t;

  state_t             state;
  logic [5:0]         count;
  logic               launch_cnt;
  logic               best_valid;
  logic               nomove_pend;
  logic               aborted;
  // Running best; copied to the best_* outputs only when a real move completes,
  // so a timeout or zero-candidate move leaves the previous result visible.
  logic [SCORE_W-1:0] run_score;
  logic [1:0]         run_rot;
  logic [3:0]         run_x;
  logic               tmo_hit;
  logic               abortable;
  logic               better;

`ifdef T01_AI_SCHED_TIMEOUT_EN
  localparam int TW = ($clog2(TIMEOUT_CYC + 1) < 10) ? 10 : $clog2(TIMEOUT_CYC + 1);
  logic [TW-1:0] tmo_cnt;

  // Watchdog counts only while parked in WAIT/EVAL; every entry into those
  // states comes from a non-counting state, which clears it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) tmo_cnt <= '0;
    else if (state == WAIT || state == EVAL) tmo_cnt <= tmo_cnt + TW'(1);
    else tmo_cnt <= '0;
  end

  assign tmo_hit = (tmo_cnt >= TW'(TIMEOUT_CYC));
`else
  assign tmo_hit = 1'b0;
`endif

  assign abortable = (state == LAUNCH) || (state == WAIT) ||
                     (state == ISSUE)  || (state == EVAL);
  assign better    = !best_valid || ($signed(eval_score) > $signed(run_score));

  // Move sequencer; all outputs are registered here.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= IDLE;
      pe_piece_type <= '0;
      pe_start      <= 1'b0;
      cand_idx      <= '0;
      eval_req      <= 1'b0;
      busy          <= 1'b0;
      move_valid    <= 1'b0;
      no_move       <= 1'b0;
      best_rot      <= '0;
      best_x        <= '0;
      best_score    <= '0;
      count         <= '0;
      launch_cnt    <= 1'b0;
      best_valid    <= 1'b0;
      nomove_pend   <= 1'b0;
      aborted       <= 1'b0;
      run_score     <= '0;
      run_rot       <= '0;
      run_x         <= '0;
    end else begin
      move_valid <= 1'b0;
      no_move    <= 1'b0;
      eval_req   <= 1'b0;
      if (abort && abortable) begin
        // Abort beats a same-cycle eval_ack: nothing is scored.
        pe_start <= 1'b0;
        aborted  <= 1'b1;
        state    <= RELEASE;
      end else begin
        case (state)
          IDLE: begin
            if (piece_valid) begin
              pe_piece_type <= piece_in;
              best_valid    <= 1'b0;
              cand_idx      <= '0;
              count         <= '0;
              launch_cnt    <= 1'b0;
              nomove_pend   <= 1'b0;
              aborted       <= 1'b0;
              pe_start      <= 1'b1;
              busy          <= 1'b1;
              state         <= LAUNCH;
            end
          end
          // Two fixed cycles: engine's ready flag may be stale until it sees start.
          LAUNCH: begin
            if (launch_cnt) state <= WAIT;
            else launch_cnt <= 1'b1;
          end
          WAIT: begin
            if (pe_ready) begin
              count <= pe_count;
              if (pe_count == 6'd0) begin
                nomove_pend <= 1'b1;
                pe_start    <= 1'b0;
                state       <= RELEASE;
              end else begin
                eval_req <= 1'b1;
                state    <= ISSUE;
              end
            end else if (tmo_hit) begin
              nomove_pend <= 1'b1;
              pe_start    <= 1'b0;
              state       <= RELEASE;
            end
          end
          ISSUE: state <= EVAL;
          EVAL: begin
            if (eval_ack) begin
              if (better) begin
                run_score  <= eval_score;
                run_rot    <= cand_rot;
                run_x      <= cand_x;
                best_valid <= 1'b1;
              end
              if (cand_idx == count - 6'd1) begin
                pe_start <= 1'b0;
                state    <= RELEASE;
              end else begin
                cand_idx <= cand_idx + 6'd1;
                eval_req <= 1'b1;
                state    <= ISSUE;
              end
            end else if (tmo_hit) begin
              nomove_pend <= 1'b1;
              pe_start    <= 1'b0;
              state       <= RELEASE;
            end
          end
          // Wait for the engine to drop ready (back in its IDLE) before reporting.
          RELEASE: begin
            if (abort) aborted <= 1'b1;
            if (!pe_ready) begin
              if (aborted || abort) begin
                busy  <= 1'b0;
                state <= IDLE;
              end else begin
                move_valid <= 1'b1;
                no_move    <= nomove_pend;
                if (!nomove_pend) begin
                  best_score <= run_score;
                  best_rot   <= run_rot;
                  best_x     <= run_x;
                end
                state <= DONE;
              end
            end
          end
          DONE: begin
            busy  <= 1'b0;
            state <= IDLE;
          end
          default: begin
            pe_start <= 1'b0;
            busy     <= 1'b0;
            state    <= IDLE;
          end
        endcase
      end
    end
  end

endmodule
